// File: rtl/inst_fetch_queue.sv
// -----------------------------------------------------------------------------
// inst_fetch_queue
//
// Circular FIFO of fetched (pc, instruction) pairs. It sits between the i-cache
// output and the fetch/decode pipeline register so that decode stalls do not
// immediately stall fetch.
//
// Ports
//   clk          in   1                clock, all state on the rising edge
//   rst_n        in   1                asynchronous reset, active low
//   i_flush      in   1                discard every queued entry
//   i_enq_valid  in   1                fetch presents a valid instruction
//   i_enq_pc     in   PC_WIDTH         pc of the presented instruction
//   i_enq_inst   in   DATA_WIDTH       presented instruction word
//   o_enq_ready  out  1                queue can accept (not full)
//   o_deq_valid  out  1                head entry valid (not empty)
//   o_deq_pc     out  PC_WIDTH         pc of the head entry (0 when empty)
//   o_deq_inst   out  DATA_WIDTH       instruction of the head entry (0 when empty)
//   i_deq_ready  in   1                decode consumes the head this cycle
//   o_count      out  $clog2(DEPTH)+1  number of occupied entries, 0..DEPTH
//
// Pointers carry one extra wrap bit above the index so that full and empty
// can be told apart without a separate occupancy counter.
// -----------------------------------------------------------------------------
module inst_fetch_queue #(
  parameter int DEPTH      = 4,
  parameter int PC_WIDTH   = 32,
  parameter int DATA_WIDTH = 32
) (
  input  logic                    clk,
  input  logic                    rst_n,
  input  logic                    i_flush,
  input  logic                    i_enq_valid,
  input  logic [PC_WIDTH-1:0]     i_enq_pc,
  input  logic [DATA_WIDTH-1:0]   i_enq_inst,
  output logic                    o_enq_ready,
  output logic                    o_deq_valid,
  output logic [PC_WIDTH-1:0]     o_deq_pc,
  output logic [DATA_WIDTH-1:0]   o_deq_inst,
  input  logic                    i_deq_ready,
  output logic [$clog2(DEPTH):0]  o_count
);

  localparam int IDX_W = $clog2(DEPTH);
  localparam int PTR_W = IDX_W + 1;

  // Pointer state (wrap bit is the MSB)
  logic [PTR_W-1:0]      r_wr_ptr;
  logic [PTR_W-1:0]      r_rd_ptr;

  // Entry storage; contents are don't-care until written, so no reset
  logic [PC_WIDTH-1:0]   r_mem_pc   [DEPTH];
  logic [DATA_WIDTH-1:0] r_mem_inst [DEPTH];

  logic [IDX_W-1:0]      w_wr_idx;
  logic [IDX_W-1:0]      w_rd_idx;
  logic                  w_empty;
  logic                  w_full;
  logic                  w_enq;
  logic                  w_deq;

  assign w_wr_idx = r_wr_ptr[IDX_W-1:0];
  assign w_rd_idx = r_rd_ptr[IDX_W-1:0];

  // Same index with different wrap bits means the writer is a full lap ahead.
  assign w_empty  = (r_wr_ptr == r_rd_ptr);
  assign w_full   = (w_wr_idx == w_rd_idx) &&
                    (r_wr_ptr[PTR_W-1] != r_rd_ptr[PTR_W-1]);

  // Ready depends only on registered pointers, so a dequeue in the same cycle
  // never opens a slot for a full queue; there is no combinational path from
  // i_deq_ready to o_enq_ready.
  assign w_enq = i_enq_valid && !w_full  && !i_flush;
  assign w_deq = i_deq_ready && !w_empty && !i_flush;

  // Pointer update. Flush takes priority over any concurrent enq/deq and
  // empties the queue by moving the read pointer onto the write pointer.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_wr_ptr <= '0;
      r_rd_ptr <= '0;
    end else if (i_flush) begin
      r_rd_ptr <= r_wr_ptr;
    end else begin
      if (w_enq) begin
        r_wr_ptr <= r_wr_ptr + PTR_W'(1);
      end
      if (w_deq) begin
        r_rd_ptr <= r_rd_ptr + PTR_W'(1);
      end
    end
  end

  // Storage write. Gated by w_enq, which already excludes full and flush.
  always_ff @(posedge clk) begin
    if (w_enq) begin
      r_mem_pc[w_wr_idx]   <= i_enq_pc;
      r_mem_inst[w_wr_idx] <= i_enq_inst;
    end
  end

  // Outputs. The head is forced to zero when empty so stale storage never
  // leaks to decode, and so the outputs read 0 while reset is asserted.
  assign o_enq_ready = !w_full;
  assign o_deq_valid = !w_empty;
  assign o_deq_pc    = w_empty ? '0 : r_mem_pc[w_rd_idx];
  assign o_deq_inst  = w_empty ? '0 : r_mem_inst[w_rd_idx];

  // Modular difference of the pointers gives occupancy 0..DEPTH directly.
  assign o_count = r_wr_ptr - r_rd_ptr;

endmodule

// File: tb/tb_inst_fetch_queue.sv
module tb_inst_fetch_queue;

  localparam int DEPTH = 4;

  logic        clk;
  logic        rst_n;
  logic        i_flush;
  logic        i_enq_valid;
  logic [31:0] i_enq_pc;
  logic [31:0] i_enq_inst;
  logic        o_enq_ready;
  logic        o_deq_valid;
  logic [31:0] o_deq_pc;
  logic [31:0] o_deq_inst;
  logic        i_deq_ready;
  logic [2:0]  o_count;

  int tests;
  int fails;

  inst_fetch_queue #(.DEPTH(DEPTH), .PC_WIDTH(32), .DATA_WIDTH(32)) dut (
    .clk         (clk),
    .rst_n       (rst_n),
    .i_flush     (i_flush),
    .i_enq_valid (i_enq_valid),
    .i_enq_pc    (i_enq_pc),
    .i_enq_inst  (i_enq_inst),
    .o_enq_ready (o_enq_ready),
    .o_deq_valid (o_deq_valid),
    .o_deq_pc    (o_deq_pc),
    .o_deq_inst  (o_deq_inst),
    .i_deq_ready (i_deq_ready),
    .o_count     (o_count)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Reference model: a plain queue of entries.
  typedef struct {
    logic [31:0] pc;
    logic [31:0] inst;
  } ent_t;

  ent_t q[$];

  always @(posedge clk or negedge rst_n) begin : model
    int  n;
    bit  e;
    bit  d;
    ent_t ent;
    if (!rst_n) begin
      q.delete();
    end else begin
      n = q.size();
      e = i_enq_valid && (n < DEPTH);
      d = i_deq_ready && (n > 0);
      if (i_flush) begin
        q.delete();
      end else begin
        if (d) void'(q.pop_front());
        if (e) begin
          ent.pc   = i_enq_pc;
          ent.inst = i_enq_inst;
          q.push_back(ent);
        end
      end
    end
  end

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    tests++;
    if (act !== exp) begin
      fails++;
      $display("FAIL %s actual=%0h expected=%0h at %0t", name, act, exp, $time);
    end
  endtask

  // Per-cycle comparison against the model, away from the active edge.
  always @(negedge clk) begin : compare
    logic [31:0] exp_pc;
    logic [31:0] exp_inst;
    exp_pc   = (q.size() > 0) ? q[0].pc   : 32'd0;
    exp_inst = (q.size() > 0) ? q[0].inst : 32'd0;
    chk("count",     64'(o_count),     64'(q.size()));
    chk("deq_valid", 64'(o_deq_valid), 64'(q.size() > 0));
    chk("enq_ready", 64'(o_enq_ready), 64'(q.size() < DEPTH));
    chk("deq_pc",    64'(o_deq_pc),    64'(exp_pc));
    chk("deq_inst",  64'(o_deq_inst),  64'(exp_inst));
  end

  function automatic logic [31:0] inst_of(input logic [31:0] pc);
    return pc ^ 32'hA5A5_0F0F;
  endfunction

  // Drive inputs, take one rising edge, return 1 time unit after it.
  task automatic step(input bit v, input logic [31:0] pc, input bit rdy, input bit fl);
    i_enq_valid = v;
    i_enq_pc    = pc;
    i_enq_inst  = inst_of(pc);
    i_deq_ready = rdy;
    i_flush     = fl;
    @(posedge clk);
    #1;
  endtask

  initial begin
    tests = 0;
    fails = 0;
    rst_n       = 1'b0;
    i_flush     = 1'b0;
    i_enq_valid = 1'b0;
    i_enq_pc    = '0;
    i_enq_inst  = '0;
    i_deq_ready = 1'b0;
    repeat (2) @(posedge clk);
    #1;
    chk("rst_count", 64'(o_count), 64'd0);
    chk("rst_ready", 64'(o_enq_ready), 64'd1);
    chk("rst_valid", 64'(o_deq_valid), 64'd0);
    chk("rst_pc",    64'(o_deq_pc), 64'd0);
    chk("rst_inst",  64'(o_deq_inst), 64'd0);
    rst_n = 1'b1;

    // Three enqueues without dequeue; head stays at the first pc.
    i_enq_valid = 1'b1;
    i_enq_pc    = 32'h100;
    chk("nobypass_valid", 64'(o_deq_valid), 64'd0);
    for (int i = 0; i < 3; i++) begin
      step(1, 32'h100 + 32'(4 * i), 0, 0);
      chk("s1_head", 64'(o_deq_pc), 64'h100);
    end
    chk("s1_count", 64'(o_count), 64'd3);

    // Fill, then a fifth enqueue must be dropped.
    step(1, 32'h10C, 0, 0);
    chk("s2_count_full", 64'(o_count), 64'd4);
    chk("s2_ready_full", 64'(o_enq_ready), 64'd0);
    step(1, 32'h200, 0, 0);
    chk("s2_count_drop", 64'(o_count), 64'd4);
    for (int i = 0; i < 4; i++) begin
      chk("s2_drain_pc", 64'(o_deq_pc), 64'(32'h100 + 32'(4 * i)));
      step(0, 32'h0, 1, 0);
    end
    chk("s2_empty", 64'(o_deq_valid), 64'd0);

    // Simultaneous enq+deq at count 2 across pointer wrap.
    step(1, 32'h300, 0, 0);
    step(1, 32'h304, 0, 0);
    for (int i = 0; i < 10; i++) begin
      chk("s3_head", 64'(o_deq_pc), 64'(32'h300 + 32'(4 * i)));
      step(1, 32'h308 + 32'(4 * i), 1, 0);
      chk("s3_count", 64'(o_count), 64'd2);
    end

    // Flush at count 3 with concurrent enq and deq.
    step(1, 32'h400, 0, 0);
    chk("s4_count3", 64'(o_count), 64'd3);
    step(1, 32'hDEAD0, 1, 1);
    chk("s4_count", 64'(o_count), 64'd0);
    chk("s4_valid", 64'(o_deq_valid), 64'd0);
    step(0, 32'h0, 0, 0);
    chk("s4_noflushed", 64'(o_deq_valid), 64'd0);

    // Empty queue with decode ready.
    for (int i = 0; i < 5; i++) begin
      step(0, 32'h0, 1, 0);
      chk("s6_count", 64'(o_count), 64'd0);
      chk("s6_valid", 64'(o_deq_valid), 64'd0);
    end

    // Asynchronous reset mid-cycle with count 2.
    step(1, 32'h500, 0, 0);
    step(1, 32'h504, 0, 0);
    chk("s5_pre", 64'(o_count), 64'd2);
    i_enq_valid = 1'b0;
    #2 rst_n = 1'b0;
    #1;
    chk("s5_valid", 64'(o_deq_valid), 64'd0);
    chk("s5_count", 64'(o_count), 64'd0);
    chk("s5_ready", 64'(o_enq_ready), 64'd1);
    @(posedge clk);
    #1 rst_n = 1'b1;

    // Random traffic against the model.
    for (int i = 0; i < 3000; i++) begin
      step(bit'($urandom_range(0, 99) < 60),
           {$urandom_range(0, 65535), 16'h0} | 32'(4 * i),
           bit'($urandom_range(0, 99) < 50),
           bit'($urandom_range(0, 99) < 4));
    end

    step(0, 32'h0, 0, 0);
    @(negedge clk);
    #1;
    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
